// File: rtl/ratio_divider_pkg.sv
// Shared constants for the ratio divider and its companion fractional multiplier.
package ratio_divider_pkg;

    // Result resolution shared by both blocks so their scaling always agrees.
    localparam int unsigned RD_DIVISOR_BITS = 7;
    localparam int unsigned RD_OPERAND_BITS = 16;
    localparam int unsigned RD_MAG_BITS     = RD_OPERAND_BITS + 1;
    localparam int unsigned RD_REM_BITS     = RD_OPERAND_BITS + 2;

endpackage

// File: rtl/ratio_divider_if.sv
// Request/result bundle of the ratio divider.
interface ratio_divider_if
    import ratio_divider_pkg::*;
#(
    parameter int unsigned DIVISOR_BITS = RD_DIVISOR_BITS
);
    logic                               start;
    logic signed [RD_OPERAND_BITS-1:0]  numerator;
    logic signed [RD_OPERAND_BITS-1:0]  denominator;
    logic        [DIVISOR_BITS-1:0]     multiple;
    logic                               negative;
    logic                               saturated;
    logic                               div_zero;
    logic                               done;

    modport master (
        output start, numerator, denominator,
        input  multiple, negative, saturated, div_zero, done
    );

    modport slave (
        input  start, numerator, denominator,
        output multiple, negative, saturated, div_zero, done
    );
endinterface

// File: rtl/ratio_divider.sv
// Sequential restoring divider returning floor(|num| * 2^DIVISOR_BITS / |den|),
// with saturation to all ones when the ratio reaches 1 or the divisor is zero.
module ratio_divider
    import ratio_divider_pkg::*;
#(
    parameter int unsigned DIVISOR_BITS = RD_DIVISOR_BITS
) (
    input  logic            clock,
    input  logic            reset,
    ratio_divider_if.slave  bus
);

    localparam int unsigned CNT_W = (DIVISOR_BITS > 1) ? $clog2(DIVISOR_BITS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        DIVIDE = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [RD_MAG_BITS-1:0]    num_mag_q, num_mag_d;
    logic [RD_MAG_BITS-1:0]    den_mag_q, den_mag_d;
    logic                      sign_q, sign_d;
    logic [RD_REM_BITS-1:0]    rem_q, rem_d;
    logic [DIVISOR_BITS-1:0]   quo_q, quo_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DIVISOR_BITS-1:0]   multiple_q, multiple_d;
    logic                      negative_q, negative_d;
    logic                      saturated_q, saturated_d;
    logic                      div_zero_q, div_zero_d;
    logic                      done_q, done_d;

    logic [RD_MAG_BITS-1:0]    num_ext, den_ext, num_abs, den_abs;
    logic [RD_REM_BITS-1:0]    rem_shift, den_wide;
    logic                      step_ge;
    logic [DIVISOR_BITS-1:0]   quo_next;

    // State and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            num_mag_q   <= '0;
            den_mag_q   <= '0;
            sign_q      <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            multiple_q  <= '0;
            negative_q  <= 1'b0;
            saturated_q <= 1'b0;
            div_zero_q  <= 1'b0;
            done_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            num_mag_q   <= num_mag_d;
            den_mag_q   <= den_mag_d;
            sign_q      <= sign_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            multiple_q  <= multiple_d;
            negative_q  <= negative_d;
            saturated_q <= saturated_d;
            div_zero_q  <= div_zero_d;
            done_q      <= done_d;
        end
    end

    // Next-state, datapath and result logic.
    always_comb begin
        state_d     = state_q;
        num_mag_d   = num_mag_q;
        den_mag_d   = den_mag_q;
        sign_d      = sign_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        multiple_d  = multiple_q;
        negative_d  = negative_q;
        saturated_d = saturated_q;
        div_zero_d  = div_zero_q;
        done_d      = done_q;

        // Magnitudes carry an extra bit so that -32768 maps to +32768 exactly.
        num_ext   = {bus.numerator[RD_OPERAND_BITS-1], bus.numerator};
        den_ext   = {bus.denominator[RD_OPERAND_BITS-1], bus.denominator};
        num_abs   = num_ext[RD_MAG_BITS-1] ? (~num_ext + RD_MAG_BITS'(1)) : num_ext;
        den_abs   = den_ext[RD_MAG_BITS-1] ? (~den_ext + RD_MAG_BITS'(1)) : den_ext;

        rem_shift = rem_q << 1;
        den_wide  = {1'b0, den_mag_q};
        step_ge   = (rem_shift >= den_wide);
        quo_next  = (quo_q << 1) | DIVISOR_BITS'(step_ge);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = LOAD;
                    done_d    = 1'b0;
                    num_mag_d = num_abs;
                    den_mag_d = den_abs;
                    sign_d    = bus.numerator[RD_OPERAND_BITS-1] ^
                                bus.denominator[RD_OPERAND_BITS-1];
                end
            end
            LOAD: begin
                if (den_mag_q == '0) begin
                    state_d     = IDLE;
                    multiple_d  = '1;
                    negative_d  = sign_q;
                    saturated_d = 1'b1;
                    div_zero_d  = 1'b1;
                    done_d      = 1'b1;
                end else if (num_mag_q >= den_mag_q) begin
                    state_d     = IDLE;
                    multiple_d  = '1;
                    negative_d  = sign_q;
                    saturated_d = 1'b1;
                    div_zero_d  = 1'b0;
                    done_d      = 1'b1;
                end else begin
                    state_d = DIVIDE;
                    rem_d   = {1'b0, num_mag_q};
                    quo_d   = '0;
                    cnt_d   = '0;
                end
            end
            DIVIDE: begin
                rem_d = step_ge ? (rem_shift - den_wide) : rem_shift;
                quo_d = quo_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DIVISOR_BITS - 1)) begin
                    state_d     = IDLE;
                    multiple_d  = quo_next;
                    negative_d  = sign_q && (quo_next != '0);
                    saturated_d = 1'b0;
                    div_zero_d  = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        endcase
    end

    assign bus.multiple  = multiple_q;
    assign bus.negative  = negative_q;
    assign bus.saturated = saturated_q;
    assign bus.div_zero  = div_zero_q;
    assign bus.done      = done_q;

endmodule
